// File: rtl/vsq_quantizer.sv
// vsq_quantizer: collects signed 24-bit MAC results into one vector, applies
// round/shift/saturate per element, derives a per-vector power-of-two scale
// for INT4_VSQ, and emits a packed 256-bit operand vector plus 8-bit scale.
// Handshakes: an element moves on every rising edge where i_valid && o_ready;
// a vector moves on every rising edge where o_valid && i_ready. o_valid/o_vec/
// o_scale/o_mode hold stable until that edge, and o_ready is never high while
// o_valid is high.
`timescale 1ns/1ps
module vsq_quantizer (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [1:0]   i_mode,
  input  logic [4:0]   i_shift,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [23:0]  i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [255:0] o_vec,
  output logic [7:0]   o_scale,
  output logic [1:0]   o_mode
);

  localparam logic [1:0] MODE_INT8 = 2'd0;
  localparam logic [1:0] MODE_INT4 = 2'd1;
  localparam logic [1:0] MODE_VSQ  = 2'd2;

  typedef enum logic [1:0] {ST_COLLECT, ST_SCALE, ST_PACK, ST_SEND} state_e;

  state_e              state_q, state_d;
  logic [5:0]          cnt_q;
  logic [1:0]          mode_q;
  logic [4:0]          shift_q;
  logic [14:0]         max_abs_q;
  logic [2:0]          e_q;
  logic                o_ready_q, o_valid_q;
  logic [255:0]        o_vec_q;
  logic [7:0]          o_scale_q;
  logic [1:0]          o_mode_q;
  logic signed [15:0]  buf_q [64];

  logic                accept, first, terminal;
  logic [1:0]          mode_norm, cur_mode;
  logic [4:0]          cur_shift;
  logic signed [32:0]  pre_ext, pre_rnd, pre_sum, pre_shr;
  logic signed [15:0]  r_sat;
  logic [14:0]         r_abs;
  logic [2:0]          e_calc;
  logic signed [16:0]  vsq_rnd, vsq_sum, vsq_shr;
  logic [255:0]        pack_vec;

  function automatic logic [7:0] sat8(input logic signed [15:0] v);
    if (v > 16'sd127)       return 8'h7F;
    else if (v < -16'sd128) return 8'h80;
    else                    return v[7:0];
  endfunction

  function automatic logic [3:0] sat4(input logic signed [16:0] v);
    if (v > 17'sd7)       return 4'h7;
    else if (v < -17'sd8) return 4'h8;
    else                  return v[3:0];
  endfunction

  assign o_ready = o_ready_q;
  assign o_valid = o_valid_q;
  assign o_vec   = o_vec_q;
  assign o_scale = o_scale_q;
  assign o_mode  = o_mode_q;

  // Element acceptance; mode and shift come straight from the ports on the
  // first element of a vector and from the latched copies afterwards.
  always_comb begin
    mode_norm = (i_mode == 2'd3) ? MODE_VSQ : i_mode;
    accept    = (state_q == ST_COLLECT) && i_valid && o_ready_q;
    first     = (cnt_q == 6'd0);
    cur_mode  = first ? mode_norm : mode_q;
    cur_shift = first ? i_shift : shift_q;
    terminal  = (cur_mode == MODE_INT8) ? (cnt_q == 6'd31) : (cnt_q == 6'd63);
  end

  // Pre-round: round-half-up arithmetic shift, then clamp to +/-32767.
  // Computed wide enough that the rounding bias can never wrap.
  always_comb begin
    pre_ext = {{9{i_data[23]}}, i_data};
    pre_rnd = (cur_shift == 5'd0) ? '0 : (33'sd1 <<< (cur_shift - 5'd1));
    pre_sum = pre_ext + pre_rnd;
    pre_shr = pre_sum >>> cur_shift;
    if (pre_shr > 33'sd32767)       r_sat = 16'sd32767;
    else if (pre_shr < -33'sd32767) r_sat = -16'sd32767;
    else                            r_sat = pre_shr[15:0];
    r_abs = 15'(r_sat[15] ? -r_sat : r_sat);
  end

  // Smallest exponent that brings max_abs into the INT4 positive range.
  always_comb begin
    e_calc = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if ((max_abs_q >> i) <= 15'd7) e_calc = 3'(i);
    end
  end

  // Final per-lane quantization and packing from the element buffer.
  always_comb begin
    pack_vec = '0;
    vsq_rnd  = (e_q == 3'd0) ? '0 : (17'sd1 <<< (e_q - 3'd1));
    vsq_sum  = '0;
    vsq_shr  = '0;
    for (int k = 0; k < 64; k++) begin
      vsq_sum = signed'({buf_q[k][15], buf_q[k]}) + vsq_rnd;
      vsq_shr = vsq_sum >>> e_q;
      case (mode_q)
        MODE_INT8: if (k < 32) pack_vec[8*k +: 8] = sat8(buf_q[k]);
        MODE_INT4: pack_vec[4*k +: 4] = sat4(signed'({buf_q[k][15], buf_q[k]}));
        default:   pack_vec[4*k +: 4] = sat4(vsq_shr);
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_COLLECT;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (accept && terminal) state_d = ST_SCALE;
      ST_SCALE:   state_d = ST_PACK;
      ST_PACK:    state_d = ST_SEND;
      ST_SEND:    if (i_ready) state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  // Datapath and handshake registers, sequenced by the current state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      mode_q    <= '0;
      shift_q   <= '0;
      max_abs_q <= '0;
      e_q       <= '0;
      o_ready_q <= 1'b0;
      o_valid_q <= 1'b0;
      o_vec_q   <= '0;
      o_scale_q <= '0;
      o_mode_q  <= '0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          o_ready_q <= 1'b1;
          if (accept) begin
            if (first) begin
              mode_q  <= mode_norm;
              shift_q <= i_shift;
            end
            if (r_abs > max_abs_q) max_abs_q <= r_abs;
            if (terminal) o_ready_q <= 1'b0;
            else          cnt_q     <= cnt_q + 6'd1;
          end
        end
        ST_SCALE: e_q <= (mode_q == MODE_VSQ) ? e_calc : 3'd0;
        ST_PACK: begin
          o_vec_q   <= pack_vec;
          o_scale_q <= (mode_q == MODE_VSQ) ? (8'd1 << e_q) : 8'd0;
          o_mode_q  <= mode_q;
          o_valid_q <= 1'b1;
        end
        ST_SEND: begin
          if (i_ready) begin
            o_valid_q <= 1'b0;
            max_abs_q <= '0;
            cnt_q     <= '0;
            o_ready_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Element buffer; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && accept) buf_q[cnt_q] <= r_sat;
  end

endmodule

// File: tb/tb_vsq_quantizer.sv
// Testbench for vsq_quantizer: scenario tasks drive vectors, a reference
// model fills the expected queue, and outputs are popped and compared.
`timescale 1ns/1ps
module tb_vsq_quantizer;

  logic         clk = 1'b0;
  logic         i_rst_n, i_valid, i_ready, o_ready, o_valid;
  logic [1:0]   i_mode, o_mode;
  logic [4:0]   i_shift;
  logic [23:0]  i_data;
  logic [255:0] o_vec;
  logic [7:0]   o_scale;

  int           cmp_cnt = 0;
  int           err_cnt = 0;
  int           elems[64];
  logic [265:0] exp_q[$];

  vsq_quantizer dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_mode(i_mode), .i_shift(i_shift),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_vec(o_vec), .o_scale(o_scale), .o_mode(o_mode)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // Reference model
  function automatic int pre_round(int x, int s);
    longint v;
    v = x;
    if (s > 0) v = v + (64'sd1 <<< (s - 1));
    v = v >>> s;
    if (v > 32767) v = 32767;
    if (v < -32767) v = -32767;
    return int'(v);
  endfunction

  function automatic int sat(int v, int lo, int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic [265:0] model(int m, int s, int n);
    int r, mx, e, q, t, me;
    logic [255:0] v;
    logic [7:0]   sc;
    me = (m == 3) ? 2 : m;
    v  = '0;
    mx = 0;
    for (int k = 0; k < n; k++) begin
      r = pre_round(elems[k], s);
      if ((r < 0 ? -r : r) > mx) mx = (r < 0 ? -r : r);
    end
    e = 0;
    if (me == 2) begin
      e = 7;
      for (int i = 7; i >= 0; i--) if ((mx >> i) <= 7) e = i;
    end
    sc = (me == 2) ? 8'(1 << e) : 8'd0;
    for (int k = 0; k < n; k++) begin
      r = pre_round(elems[k], s);
      if (me == 0) begin
        q = sat(r, -128, 127);
        v[8*k +: 8] = q[7:0];
      end else if (me == 1) begin
        q = sat(r, -8, 7);
        v[4*k +: 4] = q[3:0];
      end else begin
        t = r + ((e > 0) ? (1 << (e - 1)) : 0);
        t = t >>> e;
        q = sat(t, -8, 7);
        v[4*k +: 4] = q[3:0];
      end
    end
    return {2'(me), sc, v};
  endfunction

  // Driver: send n elements of elems[]; returns just after the last accept edge
  task automatic drive_vec(input int m, input int s, input int n,
                           input bit hold_valid, input bit push);
    int w;
    if (push) exp_q.push_back(model(m, s, n));
    for (int k = 0; k < n; k++) begin
      w = 0;
      @(negedge clk);
      while (o_ready !== 1'b1 && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (w >= 100) begin
        cmp_cnt++; err_cnt++;
        $display("FAIL drive_ready_timeout: o_ready=%b expected 1 (element %0d)", o_ready, k);
        i_valid = 1'b0;
        return;
      end
      if ($urandom_range(0, 4) == 0) begin
        i_valid = 1'b0;
        @(negedge clk);
      end
      i_valid = 1'b1;
      i_data  = 24'(elems[k]);
      if (k == 0) begin
        i_mode  = 2'(m);
        i_shift = 5'(s);
      end else begin
        i_mode  = 2'($urandom_range(0, 3));
        i_shift = 5'($urandom_range(0, 31));
      end
      @(posedge clk);
    end
    if (!hold_valid) begin
      #1;
      i_valid = 1'b0;
    end
  endtask

  // Scoreboard check: wait for o_valid, pop and compare (no handshake)
  task automatic check_output(input string name);
    int w;
    logic [265:0] e;
    w = 0;
    @(negedge clk);
    while (o_valid !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      cmp_cnt++; err_cnt++;
      $display("FAIL %s_valid_timeout: o_valid=%b expected 1", name, o_valid);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_q.size() == 0) begin
      cmp_cnt++; err_cnt++;
      $display("FAIL %s_queue: got output with queue size 0 expected 1 entry", name);
      return;
    end
    e = exp_q.pop_front();
    cmp_cnt++;
    if (o_vec !== e[255:0]) begin
      err_cnt++;
      $display("FAIL %s_vec: got %h expected %h", name, o_vec, e[255:0]);
    end
    cmp_cnt++;
    if (o_scale !== e[263:256]) begin
      err_cnt++;
      $display("FAIL %s_scale: got %0d expected %0d", name, o_scale, e[263:256]);
    end
    cmp_cnt++;
    if (o_mode !== e[265:264]) begin
      err_cnt++;
      $display("FAIL %s_mode: got %0d expected %0d", name, o_mode, e[265:264]);
    end
  endtask

  task automatic handshake(input string name);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    cmp_cnt++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL %s_handshake: got valid=%b ready=%b expected valid=0 ready=1",
               name, o_valid, o_ready);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_mode = '0; i_shift = '0; i_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp_cnt++;
    if ({o_ready, o_valid, o_vec, o_scale, o_mode} !== '0) begin
      err_cnt++;
      $display("FAIL reset_values: got ready=%b valid=%b scale=%0d mode=%0d vec=%h expected all 0",
               o_ready, o_valid, o_scale, o_mode, o_vec);
    end
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;
    cmp_cnt++;
    if (o_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_release_ready: got %b expected 1", o_ready);
    end
  endtask

  task automatic test_int8_ramp();
    for (int k = 0; k < 64; k++) elems[k] = k - 16;
    drive_vec(0, 0, 32, 0, 1);
    cmp_cnt++;
    if (o_ready !== 1'b0 || o_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL int8_ramp_e0: got ready=%b valid=%b expected 0 0", o_ready, o_valid);
    end
    @(posedge clk); #1;
    cmp_cnt++;
    if (o_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL int8_ramp_e1: got valid=%b expected 0", o_valid);
    end
    @(posedge clk); #1;
    cmp_cnt++;
    if (o_valid !== 1'b1 || o_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL int8_ramp_e2: got valid=%b ready=%b expected 1 0", o_valid, o_ready);
    end
    check_output("int8_ramp");
    cmp_cnt++;
    if (o_vec[7:0] !== 8'hF0 || o_vec[255:248] !== 8'h0F) begin
      err_cnt++;
      $display("FAIL int8_ramp_ends: got %h/%h expected f0/0f", o_vec[7:0], o_vec[255:248]);
    end
    handshake("int8_ramp");
  endtask

  task automatic test_int8_shift();
    for (int k = 0; k < 64; k++) elems[k] = 0;
    elems[0] = 24; elems[1] = -24; elems[2] = 5000; elems[3] = -100000;
    drive_vec(0, 4, 32, 0, 1);
    check_output("int8_s4");
    cmp_cnt++;
    if (o_vec[31:0] !== 32'h807F_FF02 || o_vec[255:32] !== '0) begin
      err_cnt++;
      $display("FAIL int8_s4_bytes: got %h expected 807fff02 with upper zero", o_vec);
    end
    handshake("int8_s4");
  endtask

  task automatic test_vsq();
    logic [255:0] ev;
    for (int k = 0; k < 64; k++) elems[k] = 3;
    elems[5] = 100;
    drive_vec(2, 0, 64, 0, 1);
    check_output("vsq_e4");
    ev = '0;
    ev[23:20] = 4'h6;
    cmp_cnt++;
    if (o_scale !== 8'd16 || o_vec !== ev) begin
      err_cnt++;
      $display("FAIL vsq_e4_direct: got scale=%0d vec=%h expected 16 %h", o_scale, o_vec, ev);
    end
    handshake("vsq_e4");
    for (int k = 0; k < 64; k++) elems[k] = 0;
    elems[9] = 2000;
    drive_vec(2, 0, 64, 0, 1);
    check_output("vsq_e7");
    ev = '0;
    ev[39:36] = 4'h7;
    cmp_cnt++;
    if (o_scale !== 8'd128 || o_vec !== ev) begin
      err_cnt++;
      $display("FAIL vsq_e7_direct: got scale=%0d vec=%h expected 128 %h", o_scale, o_vec, ev);
    end
    handshake("vsq_e7");
  endtask

  task automatic test_backpressure();
    logic [265:0] snap;
    for (int k = 0; k < 64; k++) elems[k] = $urandom_range(0, 4000) - 2000;
    drive_vec(0, 2, 32, 1, 1);
    check_output("bp");
    snap = {o_mode, o_scale, o_vec};
    for (int c = 0; c < 5; c++) begin
      i_data = 24'($urandom_range(0, 1000));
      @(negedge clk);
      cmp_cnt++;
      if ({o_mode, o_scale, o_vec, o_ready, o_valid} !== {snap, 1'b0, 1'b1}) begin
        err_cnt++;
        $display("FAIL bp_hold_%0d: got ready=%b valid=%b scale=%0d expected ready=0 valid=1 scale=%0d",
                 c, o_ready, o_valid, o_scale, snap[263:256]);
      end
    end
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    i_valid = 1'b0;
    cmp_cnt++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL bp_release: got ready=%b valid=%b expected 1 0", o_ready, o_valid);
    end
  endtask

  task automatic test_random_modes();
    for (int k = 0; k < 64; k++) elems[k] = $urandom_range(0, 600) - 300;
    drive_vec(1, $urandom_range(0, 6), 64, 0, 1);
    check_output("int4_rand");
    handshake("int4_rand");
    for (int k = 0; k < 64; k++) elems[k] = $urandom_range(0, 60000) - 30000;
    drive_vec(3, $urandom_range(0, 8), 64, 0, 1);
    check_output("mode3_rand");
    handshake("mode3_rand");
  endtask

  task automatic test_back_to_back();
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < 64; k++) elems[k] = $urandom_range(0, 8000) - 4000;
      drive_vec(0, $urandom_range(0, 5), 32, 0, 1);
      check_output("b2b");
      handshake("b2b");
    end
  endtask

  task automatic test_reset_mid();
    // Abort an INT4 vector, then a full INT4 vector of ones
    for (int k = 0; k < 64; k++) elems[k] = 1000;
    drive_vec(1, 0, 10, 0, 0);
    i_rst_n = 1'b0;
    @(posedge clk); #1;
    cmp_cnt++;
    if (o_ready !== 1'b0 || o_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_mid_collect: got ready=%b valid=%b expected 0 0", o_ready, o_valid);
    end
    i_rst_n = 1'b1;
    for (int k = 0; k < 64; k++) elems[k] = 1;
    drive_vec(1, 0, 64, 0, 1);
    check_output("after_abort_int4");
    cmp_cnt++;
    if (o_vec !== {64{4'h1}} || o_scale !== 8'd0) begin
      err_cnt++;
      $display("FAIL after_abort_int4_direct: got scale=%0d vec=%h expected 0 all 1", o_scale, o_vec);
    end
    handshake("after_abort_int4");
    // Abort a VSQ vector with large values; max_abs must not carry over
    for (int k = 0; k < 64; k++) elems[k] = 2000;
    drive_vec(2, 0, 10, 0, 0);
    i_rst_n = 1'b0;
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    for (int k = 0; k < 64; k++) elems[k] = 3;
    drive_vec(2, 0, 64, 0, 1);
    check_output("after_abort_vsq");
    cmp_cnt++;
    if (o_scale !== 8'd1 || o_vec !== {64{4'h3}}) begin
      err_cnt++;
      $display("FAIL after_abort_vsq_direct: got scale=%0d vec=%h expected 1 all 3", o_scale, o_vec);
    end
    // Reset while the vector is waiting in SEND
    i_rst_n = 1'b0;
    @(posedge clk); #1;
    cmp_cnt++;
    if ({o_ready, o_valid, o_vec, o_scale, o_mode} !== '0) begin
      err_cnt++;
      $display("FAIL reset_mid_send: got ready=%b valid=%b scale=%0d mode=%0d expected all 0",
               o_ready, o_valid, o_scale, o_mode);
    end
    i_rst_n = 1'b1;
    for (int k = 0; k < 64; k++) elems[k] = -5;
    drive_vec(1, 0, 64, 0, 1);
    check_output("after_send_reset");
    handshake("after_send_reset");
  endtask

  // Sequence and report
  initial begin
    test_reset();
    test_int8_ramp();
    test_int8_shift();
    test_vsq();
    test_backpressure();
    test_random_modes();
    test_back_to_back();
    test_reset_mid();
    cmp_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL queue_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
